// File: rtl/parking_lot_controller.sv
// Occupancy manager for an 8-space car park.
// Gives each arriving car the lowest-numbered free space and frees a space when a car
// leaves. One FSM handles entry and exit requests one at a time, and exit wins a tie.
// The occupancy bit order matches exit_parking_lot, so both blocks can drive the
// location displays from the same decode.
//
// Ports
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   entry_req         car at entry gate; level, held until entry_grant/entry_reject
//   exit_req          car at exit gate; level, held until exit_ack/exit_err
//   exit_park_number  space being vacated; stable while exit_req is high
//   entry_grant       1-cycle pulse: a space was assigned
//   entry_reject      1-cycle pulse: lot full, no space assigned
//   entry_park_number assigned space; valid with entry_grant and held afterwards
//   exit_ack          1-cycle pulse: space released
//   exit_err          1-cycle pulse: named space was already free
//   occupancy         bit (7-n) set = space n occupied
//   free_count        number of free spaces, 0..8
//   full / empty      free_count == 0 / free_count == 8
module parking_lot_controller #(
  parameter int unsigned NUM_SPACES = 8,
  parameter int unsigned IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  entry_req,
  input  logic                  exit_req,
  input  logic [IDX_W-1:0]      exit_park_number,
  output logic                  entry_grant,
  output logic                  entry_reject,
  output logic [IDX_W-1:0]      entry_park_number,
  output logic                  exit_ack,
  output logic                  exit_err,
  output logic [NUM_SPACES-1:0] occupancy,
  output logic [IDX_W:0]        free_count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned CntW = IDX_W + 1;

  typedef enum logic [1:0] {StIdle, StAlloc, StExit, StRelease} state_e;

  state_e                state_q, state_d;
  // Records which request is waiting to be released: 1 = exit, 0 = entry.
  logic                  served_exit_q, served_exit_d;
  logic [NUM_SPACES-1:0] occ_d;
  logic [CntW-1:0]       free_d;
  logic [IDX_W-1:0]      park_d;
  logic                  grant_d, reject_d, ack_d, err_d;
  logic [IDX_W-1:0]      lowest_free;
  logic [IDX_W-1:0]      exit_bit;

  // Lowest free space number. The loop scans downward, so the last hit is the lowest.
  // The result is only used in StAlloc, and that state is never entered when the lot is full.
  always_comb begin
    lowest_free = '0;
    for (int i = int'(NUM_SPACES) - 1; i >= 0; i--) begin
      if (!occupancy[IDX_W'(int'(NUM_SPACES) - 1 - i)]) begin
        lowest_free = IDX_W'(i);
      end
    end
  end

  assign exit_bit = IDX_W'(NUM_SPACES - 1) - exit_park_number;

  always_comb begin
    state_d       = state_q;
    served_exit_d = served_exit_q;
    occ_d         = occupancy;
    free_d        = free_count;
    park_d        = entry_park_number;
    grant_d       = 1'b0;
    reject_d      = 1'b0;
    ack_d         = 1'b0;
    err_d         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (exit_req) begin
          // Exit goes first, so a full lot can make room for a waiting entry.
          served_exit_d = 1'b1;
          state_d       = StExit;
        end else if (entry_req) begin
          served_exit_d = 1'b0;
          if (full) begin
            reject_d = 1'b1;
            state_d  = StRelease;
          end else begin
            state_d = StAlloc;
          end
        end
      end
      StAlloc: begin
        occ_d[IDX_W'(NUM_SPACES - 1) - lowest_free] = 1'b1;
        free_d  = free_count - CntW'(1);
        park_d  = lowest_free;
        grant_d = 1'b1;
        state_d = StRelease;
      end
      StExit: begin
        if (occupancy[exit_bit]) begin
          occ_d[exit_bit] = 1'b0;
          free_d          = free_count + CntW'(1);
          ack_d           = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = StRelease;
      end
      StRelease: begin
        // Wait here until the served request drops, so a held request is served only once.
        if (served_exit_q ? !exit_req : !entry_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      served_exit_q     <= 1'b0;
      occupancy         <= '0;
      free_count        <= CntW'(NUM_SPACES);
      full              <= 1'b0;
      empty             <= 1'b1;
      entry_park_number <= '0;
      entry_grant       <= 1'b0;
      entry_reject      <= 1'b0;
      exit_ack          <= 1'b0;
      exit_err          <= 1'b0;
    end else begin
      state_q           <= state_d;
      served_exit_q     <= served_exit_d;
      occupancy         <= occ_d;
      free_count        <= free_d;
      // Computed from the next count, so full/empty change on the same edge as occupancy.
      full              <= (free_d == '0);
      empty             <= (free_d == CntW'(NUM_SPACES));
      entry_park_number <= park_d;
      entry_grant       <= grant_d;
      entry_reject      <= reject_d;
      exit_ack          <= ack_d;
      exit_err          <= err_d;
    end
  end

endmodule

// File: tb/tb_parking_lot_controller.sv
// Self-checking bench for parking_lot_controller.
// A reference model stores which spaces are taken as an array of flags. The bench
// runs directed scenarios and then random entry/exit handshakes against that model.
module tb_parking_lot_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [2:0] exit_park_number = '0;
  logic       entry_grant, entry_reject, exit_ack, exit_err;
  logic [2:0] entry_park_number;
  logic [7:0] occupancy;
  logic [3:0] free_count;
  logic       full, empty;

  int n_vectors = 0;
  int n_miscompares = 0;

  bit         model_occ[8];
  logic [2:0] model_last = '0;

  parking_lot_controller dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .entry_req         (entry_req),
    .exit_req          (exit_req),
    .exit_park_number  (exit_park_number),
    .entry_grant       (entry_grant),
    .entry_reject      (entry_reject),
    .entry_park_number (entry_park_number),
    .exit_ack          (exit_ack),
    .exit_err          (exit_err),
    .occupancy         (occupancy),
    .free_count        (free_count),
    .full              (full),
    .empty             (empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_free();
    int c = 0;
    for (int i = 0; i < 8; i++) if (!model_occ[i]) c++;
    return c;
  endfunction

  function automatic logic [7:0] model_vec();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[3'(7 - i)] = model_occ[i];
    return v;
  endfunction

  function automatic int model_lowest();
    for (int i = 0; i < 8; i++) if (!model_occ[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] pulses();
    return {entry_grant, entry_reject, exit_ack, exit_err};
  endfunction

  task automatic check_status(input string tag);
    check_eq({tag, ".occupancy"}, 32'(occupancy), 32'(model_vec()));
    check_eq({tag, ".free_count"}, 32'(free_count), 32'(model_free()));
    check_eq({tag, ".full"}, 32'(full), 32'(model_free() == 0));
    check_eq({tag, ".empty"}, 32'(empty), 32'(model_free() == 8));
    check_eq({tag, ".park_number"}, 32'(entry_park_number), 32'(model_last));
  endtask

  // Wait up to 20 cycles for the next response pulse. cyc = -1 means the wait timed out.
  task automatic wait_pulse(output int cyc, output logic [3:0] p);
    int i = 0;
    cyc = -1;
    p   = '0;
    while (i < 20 && cyc < 0) begin
      @(negedge clk);
      i++;
      p = pulses();
      if (p != '0) cyc = i;
    end
  endtask

  // A request held past its response must not produce another pulse.
  task automatic hold_check(input int hold);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      check_eq("no_repeat", 32'(pulses()), 32'h0);
    end
  endtask

  task automatic expect_entry(input int cyc, input logic [3:0] p, input int lat_grant,
                              input int lat_reject);
    int n;
    n = model_lowest();
    if (n >= 0) begin
      check_eq("entry_resp", 32'(p), 32'b1000);
      check_eq("entry_lat", 32'(cyc), 32'(lat_grant));
      model_occ[n] = 1'b1;
      model_last   = 3'(n);
    end else begin
      check_eq("entry_resp", 32'(p), 32'b0100);
      check_eq("entry_lat", 32'(cyc), 32'(lat_reject));
    end
    check_status("entry");
  endtask

  task automatic expect_exit(input int n, input int cyc, input logic [3:0] p);
    if (model_occ[n]) begin
      check_eq("exit_resp", 32'(p), 32'b0010);
      model_occ[n] = 1'b0;
    end else begin
      check_eq("exit_resp", 32'(p), 32'b0001);
    end
    check_eq("exit_lat", 32'(cyc), 32'd2);
    check_status("exit");
  endtask

  task automatic do_entry(input int hold);
    int cyc;
    logic [3:0] p;
    entry_req = 1'b1;
    wait_pulse(cyc, p);
    expect_entry(cyc, p, 2, 1);
    hold_check(hold);
    entry_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_exit(input int n, input int hold);
    int cyc;
    logic [3:0] p;
    exit_park_number = 3'(n);
    exit_req = 1'b1;
    wait_pulse(cyc, p);
    expect_exit(n, cyc, p);
    hold_check(hold);
    exit_req = 1'b0;
    @(negedge clk);
  endtask

  // Raise both requests together. Exit is served first; entry follows once exit_req drops.
  task automatic do_both(input int n);
    int cyc;
    logic [3:0] p;
    exit_park_number = 3'(n);
    exit_req  = 1'b1;
    entry_req = 1'b1;
    wait_pulse(cyc, p);
    expect_exit(n, cyc, p);
    exit_req = 1'b0;
    wait_pulse(cyc, p);
    expect_entry(cyc, p, 3, 2);
    hold_check(0);
    entry_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) model_occ[i] = 1'b0;
    model_last = '0;
    check_status("reset");
    check_eq("reset.pulses", 32'(pulses()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    logic [3:0] p;
    int op;

    // Power-on reset
    repeat (2) @(negedge clk);
    check_status("por");
    check_eq("por.pulses", 32'(pulses()), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exit of a free space reports an error
    do_exit(5, 0);
    check_eq("err.occ", 32'(occupancy), 32'h00);
    check_eq("err.free", 32'(free_count), 32'd8);

    // Fill the lot in order, then one more entry is rejected
    for (int i = 0; i < 8; i++) do_entry(i % 3);
    check_eq("fill.occ", 32'(occupancy), 32'hFF);
    check_eq("fill.full", 32'(full), 32'd1);
    do_entry(1);
    check_eq("reject.occ", 32'(occupancy), 32'hFF);

    // Release space 3, and the next entry gets space 3 back
    do_exit(3, 0);
    check_eq("exit3.occ", 32'(occupancy), 32'hEF);
    check_eq("exit3.free", 32'(free_count), 32'd1);
    do_entry(0);
    check_eq("reuse.park", 32'(entry_park_number), 32'd3);

    // Simultaneous requests on a full lot
    do_both(6);
    check_eq("both.occ", 32'(occupancy), 32'hFF);
    check_eq("both.park", 32'(entry_park_number), 32'd6);

    // Reset while in ALLOC; the entry request stays high through reset
    do_exit(1, 0);
    entry_req = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) model_occ[i] = 1'b0;
    model_last = '0;
    check_status("alloc_rst");
    check_eq("alloc_rst.pulses", 32'(pulses()), 32'h0);
    @(negedge clk);
    check_eq("alloc_rst.nogrant", 32'(pulses()), 32'h0);
    rst_n = 1'b1;
    wait_pulse(cyc, p);
    expect_entry(cyc, p, 2, 1);
    check_eq("alloc_rst.park", 32'(entry_park_number), 32'd0);
    entry_req = 1'b0;
    @(negedge clk);

    // Random handshakes checked against the model
    for (int k = 0; k < 250; k++) begin
      op = int'($urandom_range(0, 99));
      if (op < 50) do_entry(int'($urandom_range(0, 2)));
      else if (op < 88) do_exit(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      else if (op < 98) do_both(int'($urandom_range(0, 7)));
      else apply_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
